ov7670_pool: RTL and testbench

Streaming average-pool stage that sits directly downstream of the OV7670 capture stage. It consumes the capture stage's per-pixel luma write stream (address, byte, write strobe) in the `pclk` domain. It crops a centred square window and box-averages it into an OUT_DIM×OUT_DIM 8-bit image, writing the result into the CNN input buffer. A `hold` input lets the CNN freeze the buffer: frames that start while `hold` is high are skipped whole.

---
 rtl/ov7670_pool.sv | 136 +++++++++++++
 tb/tb_ov7670_pool.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pool.sv
// Crops a centred window from the capture stage's luma write stream and box-averages it
// into an OUT_DIM x OUT_DIM image for the CNN input buffer; frames started under hold are skipped.
module ov7670_pool #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int X0      = 96,
   parameter int Y0      = 16,
   parameter int BLK     = 16,
   parameter int OUT_DIM = 28
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [18:0] pix_addr,
   input  logic [7:0]  pix_data,
   input  logic        pix_we,
   input  logic        hold,
   output logic [9:0]  out_addr,
   output logic [7:0]  out_data,
   output logic        out_we,
   output logic        frame_done
);

   localparam int LB    = $clog2(BLK);
   localparam int ACC_W = 8 + 2*LB;
   localparam int XW    = $clog2(IMG_W + 1);
   localparam int YW    = $clog2(IMG_H + 1);
   localparam int BW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int WIN   = BLK * OUT_DIM;

   localparam logic [XW-1:0] X_LO   = XW'(X0);
   localparam logic [XW-1:0] X_HI   = XW'(X0 + WIN);
   localparam logic [XW-1:0] X_END  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LO   = YW'(Y0);
   localparam logic [YW-1:0] Y_HI   = YW'(Y0 + WIN);
   localparam logic [YW-1:0] Y_SAT  = YW'(IMG_H);
   localparam logic [BW-1:0] B_LAST = BW'(OUT_DIM - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

   state_t state, state_nx;

   // nx/ny hold the position the next non-frame-start pixel will occupy
   logic [XW-1:0]    nx, cur_x, lx;
   logic [YW-1:0]    ny, cur_y, ly;
   logic [BW-1:0]    bx, by;
   logic [ACC_W-1:0] acc [OUT_DIM];
   logic [ACC_W-1:0] sum;
   logic [9:0]       addr_c;
   logic             frame_start, valid_pos, in_win, blk_last;
   logic             acc_en, wr_en, done_en;

   assign frame_start = pix_we && (pix_addr == 19'd0);
   assign cur_x       = frame_start ? '0 : nx;
   assign cur_y       = frame_start ? '0 : ny;
   assign valid_pos   = (cur_y != Y_SAT);
   assign lx          = cur_x - X_LO;
   assign ly          = cur_y - Y_LO;
   assign in_win      = (cur_x >= X_LO) && (cur_x < X_HI) && (cur_y >= Y_LO) && (cur_y < Y_HI);
   assign bx          = BW'(lx >> LB);
   assign by          = BW'(ly >> LB);
   assign blk_last    = (lx[LB-1:0] == '1) && (ly[LB-1:0] == '1);
   assign sum         = acc[bx] + ACC_W'(pix_data);
   assign addr_c      = 10'(by) * 10'(OUT_DIM) + 10'(bx);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      acc_en   = 1'b0;
      wr_en    = 1'b0;
      done_en  = 1'b0;
      if (frame_start) begin
         // a frame start always wins over any block completing in the same cycle
         state_nx = hold ? SKIP : ACTIVE;
         acc_en   = !hold && in_win;
      end else if (pix_we && state == ACTIVE && valid_pos && in_win) begin
         if (blk_last) begin
            wr_en = 1'b1;
            if (bx == B_LAST && by == B_LAST) begin
               done_en  = 1'b1;
               state_nx = IDLE;
            end
         end else begin
            acc_en = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         nx <= '0;
         ny <= '0;
      end else if (frame_start) begin
         nx <= XW'(1);
         ny <= '0;
      end else if (pix_we && state != IDLE && valid_pos) begin
         if (cur_x == X_END) begin
            nx <= '0;
            ny <= ny + YW'(1);
         end else begin
            nx <= nx + XW'(1);
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
      end else begin
         if (frame_start)
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
         if (acc_en) acc[bx] <= frame_start ? ACC_W'(pix_data) : sum;
         if (wr_en)  acc[bx] <= '0;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         out_addr   <= '0;
         out_data   <= '0;
         out_we     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_we     <= wr_en;
         frame_done <= done_en;
         if (wr_en) begin
            out_addr <= addr_c;
            out_data <= sum[ACC_W-1 -: 8];
         end
      end
   end

endmodule

// File: tb/tb_ov7670_pool.sv
// Bench for ov7670_pool on a reduced geometry: table of whole frames plus restart/reset sequences.
module tb_ov7670_pool;

   localparam int W  = 64;
   localparam int H  = 48;
   localparam int X0 = 8;
   localparam int Y0 = 4;
   localparam int BLK = 4;
   localparam int OD = 10;
   localparam int LAST = OD*OD - 1;
   localparam int FULL = W*H;
   localparam int M_UNI = 0, M_BLK = 1, M_TRC = 2;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic [18:0] pix_addr;
   logic [7:0]  pix_data;
   logic        pix_we;
   logic        hold;
   logic [9:0]  out_addr;
   logic [7:0]  out_data;
   logic        out_we;
   logic        frame_done;

   ov7670_pool #(.IMG_W(W), .IMG_H(H), .X0(X0), .Y0(Y0), .BLK(BLK), .OUT_DIM(OD)) dut (
      .pclk(pclk), .rst_n(rst_n), .pix_addr(pix_addr), .pix_data(pix_data),
      .pix_we(pix_we), .hold(hold), .out_addr(out_addr), .out_data(out_data),
      .out_we(out_we), .frame_done(frame_done)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      int         mode;
      logic [7:0] fill;
      bit         hv;
      bit         gaps;
      int         exp_wr;
      int         exp_done;
   } vec_t;

   wr_t  sb[$];
   vec_t tbl[6];
   int   checks = 0;
   int   errors = 0;
   int   n_wr   = 0;
   int   n_done = 0;

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic bit inwin(int x, int y);
      return x >= X0 && x < X0 + BLK*OD && y >= Y0 && y < Y0 + BLK*OD;
   endfunction

   function automatic logic [7:0] pix_val(int mode, logic [7:0] fill, int x, int y);
      if (!inwin(x, y)) return (mode == M_UNI) ? fill : 8'hFF;
      case (mode)
         M_UNI:   return fill;
         M_BLK:   return 8'(((((x - X0) / BLK) * 9) + ((y - Y0) / BLK)) & 255);
         default: return (((x - X0) % BLK == 0) && ((y - Y0) % BLK == 0)) ? 8'h00 : 8'h01;
      endcase
   endfunction

   function automatic logic [7:0] exp_block(int mode, logic [7:0] fill, int bx, int by);
      int s = 0;
      for (int j = 0; j < BLK; j++)
         for (int i = 0; i < BLK; i++)
            s += int'(pix_val(mode, fill, X0 + bx*BLK + i, Y0 + by*BLK + j));
      return 8'(s / (BLK*BLK));
   endfunction

   task automatic drive_frame(int mode, logic [7:0] fill, bit hv, bit gaps, int npix);
      for (int p = 0; p < npix; p++) begin
         int x, y, bx, by;
         wr_t e;
         x = p % W;
         y = p / W;
         pix_addr = 19'(p);
         pix_data = pix_val(mode, fill, x, y);
         pix_we   = 1'b1;
         hold     = (p == 0) ? hv : 1'($urandom_range(0, 1));
         if (!hv && inwin(x, y) && (x - X0) % BLK == BLK - 1 && (y - Y0) % BLK == BLK - 1) begin
            bx = (x - X0) / BLK;
            by = (y - Y0) / BLK;
            e.addr = 10'(by*OD + bx);
            e.data = exp_block(mode, fill, bx, by);
            sb.push_back(e);
         end
         @(posedge pclk); #1;
         pix_we = 1'b0;
         if (gaps && $urandom_range(0, 4) == 0) begin
            @(posedge pclk); #1;
         end
      end
      pix_we = 1'b0;
      hold   = 1'b0;
   endtask

   task automatic settle_and_check(string tag, int exp_wr, int exp_done);
      repeat (4) @(posedge pclk);
      #1;
      chk({tag, "_writes"}, n_wr, exp_wr);
      chk({tag, "_done"}, n_done, exp_done);
      chk({tag, "_sb_left"}, sb.size(), 0);
      sb.delete();
      n_wr   = 0;
      n_done = 0;
   endtask

   always @(negedge pclk) begin
      if (rst_n) begin
         if (out_we) begin
            wr_t e;
            n_wr++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0h, none expected", out_addr, out_data);
            end else begin
               e = sb.pop_front();
               if (out_addr !== e.addr || out_data !== e.data) begin
                  errors++;
                  $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                           out_addr, out_data, e.addr, e.data);
               end
            end
         end
         if (frame_done) begin
            n_done++;
            checks++;
            if (!(out_we && out_addr == 10'(LAST))) begin
               errors++;
               $display("FAIL done_align: out_we %0b addr %0d expected 1 and %0d", out_we, out_addr, LAST);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{mode: M_UNI, fill: 8'h80, hv: 1'b0, gaps: 1'b0, exp_wr: OD*OD, exp_done: 1};
      tbl[1] = '{mode: M_BLK, fill: 8'h00, hv: 1'b0, gaps: 1'b1, exp_wr: OD*OD, exp_done: 1};
      tbl[2] = '{mode: M_TRC, fill: 8'h00, hv: 1'b0, gaps: 1'b0, exp_wr: OD*OD, exp_done: 1};
      tbl[3] = '{mode: M_UNI, fill: 8'hFF, hv: 1'b0, gaps: 1'b1, exp_wr: OD*OD, exp_done: 1};
      tbl[4] = '{mode: M_UNI, fill: 8'h40, hv: 1'b1, gaps: 1'b0, exp_wr: 0,     exp_done: 0};
      tbl[5] = '{mode: M_BLK, fill: 8'h00, hv: 1'b0, gaps: 1'b0, exp_wr: OD*OD, exp_done: 1};

      rst_n    = 1'b0;
      pix_addr = '0;
      pix_data = '0;
      pix_we   = 1'b0;
      hold     = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_out_we", out_we, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_done", frame_done, 0);
      @(negedge pclk);
      rst_n = 1'b1;
      @(posedge pclk); #1;

      for (int t = 0; t < 6; t++) begin
         drive_frame(tbl[t].mode, tbl[t].fill, tbl[t].hv, tbl[t].gaps, FULL);
         settle_and_check($sformatf("vec%0d", t), tbl[t].exp_wr, tbl[t].exp_done);
      end

      // restart: partial frame with accumulators mid-block, then a fresh frame
      drive_frame(M_UNI, 8'hFF, 1'b0, 1'b0, 22*W);
      drive_frame(M_BLK, 8'h00, 1'b0, 1'b0, FULL);
      settle_and_check("restart", 4*OD + OD*OD, 1);

      // reset mid-frame during row 30 (no block completes in that row)
      drive_frame(M_BLK, 8'h00, 1'b0, 1'b0, 30*W + 20);
      @(posedge pclk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_we", out_we, 0);
      chk("midrst_out_addr", out_addr, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_frame_done", frame_done, 0);
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      @(posedge pclk); #1;
      settle_and_check("midrst", 6*OD, 0);
      drive_frame(M_UNI, 8'h33, 1'b0, 1'b1, FULL);
      settle_and_check("post_rst", OD*OD, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
